fetch_decoder: RTL

Front-end fetch and decode stage sitting directly upstream of the FP op queue. It fetches one RV32I instruction at a time from the instruction cache and decodes it into the queue's 55-bit bundle {op, rd, rs1, rs2, imm, branch, ls, use_imm}. It redirects itself on JAL, stalls behind JALR until the target resolves, and honours back-pressure from the queue's `full` flag. It outputs an all-zero bundle whenever it has nothing to send, because the queue writes every non-full cycle.

---
 rtl/fetch_decoder.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_decoder.sv
// fetch_decoder: single-issue RV32I fetch and decode front end feeding the FP op
// queue. Holds one decoded 55-bit bundle in an output slot, follows JAL
// directly, parks behind JALR until its target resolves, and drops the response
// of any fetch that was in flight when a redirect arrived.
module fetch_decoder #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_valid_in,
    input  logic [31:0] mem_inst_in,
    input  logic        full_in,
    output logic [4:0]  op_out,
    output logic [4:0]  rd_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic [31:0] imm_out,
    output logic        branch_out,
    output logic        ls_out,
    output logic        use_imm_out,
    output logic [31:0] jalr_pc_out,
    input  logic        jalr_done_in,
    input  logic [31:0] jalr_target_in,
    input  logic        redirect_valid_in,
    input  logic [31:0] redirect_pc_in
);

    // Queue op codes; 0 is the NOP bundle.
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SLL  = 5'd3;
    localparam logic [4:0] OP_SLT  = 5'd4;
    localparam logic [4:0] OP_SLTU = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_SRL  = 5'd7;
    localparam logic [4:0] OP_SRA  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_AND  = 5'd10;
    localparam logic [4:0] OP_LUI  = 5'd11;
    localparam logic [4:0] OP_JAL  = 5'd12;
    localparam logic [4:0] OP_JALR = 5'd13;
    localparam logic [4:0] OP_BEQ  = 5'd14;
    localparam logic [4:0] OP_BNE  = 5'd15;
    localparam logic [4:0] OP_BLT  = 5'd16;
    localparam logic [4:0] OP_BGE  = 5'd17;
    localparam logic [4:0] OP_BLTU = 5'd18;
    localparam logic [4:0] OP_BGEU = 5'd19;
    localparam logic [4:0] OP_LB   = 5'd20;
    localparam logic [4:0] OP_LH   = 5'd21;
    localparam logic [4:0] OP_LW   = 5'd22;
    localparam logic [4:0] OP_LBU  = 5'd23;
    localparam logic [4:0] OP_LHU  = 5'd24;
    localparam logic [4:0] OP_SB   = 5'd25;
    localparam logic [4:0] OP_SH   = 5'd26;
    localparam logic [4:0] OP_SW   = 5'd27;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        WAIT_MEM  = 2'd1,
        WAIT_JALR = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] jalr_pc;
    logic        drop;

    // Output slot: one decoded bundle plus its valid bit
    logic        vld_p1;
    logic [4:0]  op_p1, rd_p1, rs1_p1, rs2_p1;
    logic [31:0] imm_p1;
    logic        branch_p1, ls_p1, use_imm_p1;

    // Decoder result for the word on mem_inst_in
    logic [4:0]  dec_op_p0, dec_rd_p0, dec_rs1_p0, dec_rs2_p0;
    logic [31:0] dec_imm_p0;
    logic        dec_branch_p0, dec_ls_p0, dec_use_imm_p0;
    logic        dec_jal_p0, dec_jalr_p0, dec_nop_p0;

    logic [31:0] inst;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic        consume;
    logic        issue;
    logic        load;
    logic        outstanding;

    assign inst  = mem_inst_in;
    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // The bundle leaves only on an enabled, non-full edge; a new fetch may
    // overlap that edge. Reset holds the request low.
    assign consume     = vld_p1 && !full_in && rdy_in;
    assign issue       = (state == FETCH) && !drop && (!vld_p1 || !full_in) && !rst_in;
    assign load        = (state == WAIT_MEM) && mem_valid_in;
    assign outstanding = ((state == WAIT_MEM) && !mem_valid_in) || issue
                         || (drop && !mem_valid_in);

    assign mem_req_out  = issue || (state == WAIT_MEM);
    assign mem_addr_out = mem_req_out ? {pc[31:2], 2'b00} : 32'h0;
    assign jalr_pc_out  = (state == WAIT_JALR) ? jalr_pc : 32'h0;

    assign op_out      = vld_p1 ? op_p1      : 5'h0;
    assign rd_out      = vld_p1 ? rd_p1      : 5'h0;
    assign rs1_out     = vld_p1 ? rs1_p1     : 5'h0;
    assign rs2_out     = vld_p1 ? rs2_p1     : 5'h0;
    assign imm_out     = vld_p1 ? imm_p1     : 32'h0;
    assign branch_out  = vld_p1 && branch_p1;
    assign ls_out      = vld_p1 && ls_p1;
    assign use_imm_out = vld_p1 && use_imm_p1;

    // Decode one RV32I word into the queue bundle; anything unsupported is a NOP
    always_comb begin
        dec_op_p0      = OP_NOP;
        dec_rd_p0      = inst[11:7];
        dec_rs1_p0     = inst[19:15];
        dec_rs2_p0     = 5'h0;
        dec_imm_p0     = 32'h0;
        dec_branch_p0  = 1'b0;
        dec_ls_p0      = 1'b0;
        dec_use_imm_p0 = 1'b0;
        dec_jal_p0     = 1'b0;
        dec_jalr_p0    = 1'b0;
        dec_nop_p0     = 1'b0;
        case (opc)
            7'b0110011: begin
                dec_rs2_p0 = inst[24:20];
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    case (f3)
                        3'b000:  dec_op_p0 = f7[5] ? OP_SUB : OP_ADD;
                        3'b001:  dec_op_p0 = OP_SLL;
                        3'b010:  dec_op_p0 = OP_SLT;
                        3'b011:  dec_op_p0 = OP_SLTU;
                        3'b100:  dec_op_p0 = OP_XOR;
                        3'b101:  dec_op_p0 = f7[5] ? OP_SRA : OP_SRL;
                        3'b110:  dec_op_p0 = OP_OR;
                        default: dec_op_p0 = OP_AND;
                    endcase
                end else begin
                    dec_nop_p0 = 1'b1;
                end
            end
            7'b0010011: begin
                dec_use_imm_p0 = 1'b1;
                dec_imm_p0     = imm_i;
                case (f3)
                    3'b000:  dec_op_p0 = OP_ADD;
                    3'b010:  dec_op_p0 = OP_SLT;
                    3'b011:  dec_op_p0 = OP_SLTU;
                    3'b100:  dec_op_p0 = OP_XOR;
                    3'b110:  dec_op_p0 = OP_OR;
                    3'b111:  dec_op_p0 = OP_AND;
                    3'b001: begin
                        dec_op_p0  = OP_SLL;
                        dec_imm_p0 = {27'b0, inst[24:20]};
                        dec_nop_p0 = (f7 != 7'b0000000);
                    end
                    default: begin
                        dec_op_p0  = f7[5] ? OP_SRA : OP_SRL;
                        dec_imm_p0 = {27'b0, inst[24:20]};
                        dec_nop_p0 = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    end
                endcase
            end
            7'b0110111: begin
                dec_op_p0  = OP_LUI;
                dec_rs1_p0 = 5'h0;
                dec_imm_p0 = imm_u;
            end
            7'b0010111: begin
                // AUIPC becomes a LUI of the already-added value
                dec_op_p0  = OP_LUI;
                dec_rs1_p0 = 5'h0;
                dec_imm_p0 = pc + imm_u;
            end
            7'b1101111: begin
                dec_op_p0  = OP_JAL;
                dec_rs1_p0 = 5'h0;
                dec_imm_p0 = pc + 32'd4;
                dec_jal_p0 = 1'b1;
            end
            7'b1100111: begin
                dec_op_p0   = OP_JALR;
                dec_imm_p0  = imm_i;
                dec_jalr_p0 = 1'b1;
                dec_nop_p0  = (f3 != 3'b000);
            end
            7'b1100011: begin
                dec_rd_p0     = 5'h0;
                dec_rs2_p0    = inst[24:20];
                dec_branch_p0 = 1'b1;
                dec_imm_p0    = pc + imm_b;
                case (f3)
                    3'b000:  dec_op_p0 = OP_BEQ;
                    3'b001:  dec_op_p0 = OP_BNE;
                    3'b100:  dec_op_p0 = OP_BLT;
                    3'b101:  dec_op_p0 = OP_BGE;
                    3'b110:  dec_op_p0 = OP_BLTU;
                    3'b111:  dec_op_p0 = OP_BGEU;
                    default: dec_nop_p0 = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec_ls_p0  = 1'b1;
                dec_imm_p0 = imm_i;
                case (f3)
                    3'b000:  dec_op_p0 = OP_LB;
                    3'b001:  dec_op_p0 = OP_LH;
                    3'b010:  dec_op_p0 = OP_LW;
                    3'b100:  dec_op_p0 = OP_LBU;
                    3'b101:  dec_op_p0 = OP_LHU;
                    default: dec_nop_p0 = 1'b1;
                endcase
            end
            7'b0100011: begin
                dec_rd_p0  = 5'h0;
                dec_rs2_p0 = inst[24:20];
                dec_ls_p0  = 1'b1;
                dec_imm_p0 = imm_s;
                case (f3)
                    3'b000:  dec_op_p0 = OP_SB;
                    3'b001:  dec_op_p0 = OP_SH;
                    3'b010:  dec_op_p0 = OP_SW;
                    default: dec_nop_p0 = 1'b1;
                endcase
            end
            default: dec_nop_p0 = 1'b1;
        endcase
        if (dec_nop_p0) begin
            dec_op_p0      = OP_NOP;
            dec_rd_p0      = 5'h0;
            dec_rs1_p0     = 5'h0;
            dec_rs2_p0     = 5'h0;
            dec_imm_p0     = 32'h0;
            dec_branch_p0  = 1'b0;
            dec_ls_p0      = 1'b0;
            dec_use_imm_p0 = 1'b0;
            dec_jal_p0     = 1'b0;
            dec_jalr_p0    = 1'b0;
        end
    end

    // ---- p0 -> p1: capture the decoded bundle into the slot (data, no reset)
    always_ff @(posedge clk_in) begin
        if (rdy_in && !redirect_valid_in && load) begin
            op_p1      <= dec_op_p0;
            rd_p1      <= dec_rd_p0;
            rs1_p1     <= dec_rs1_p0;
            rs2_p1     <= dec_rs2_p0;
            imm_p1     <= dec_imm_p0;
            branch_p1  <= dec_branch_p0;
            ls_p1      <= dec_ls_p0;
            use_imm_p1 <= dec_use_imm_p0;
        end
    end

    // Fetch FSM, pc, drop flag and slot valid; redirect overrides everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            jalr_pc <= 32'h0;
            drop    <= 1'b0;
            vld_p1  <= 1'b0;
        end else if (rdy_in) begin
            if (redirect_valid_in) begin
                state  <= FETCH;
                pc     <= redirect_pc_in;
                vld_p1 <= 1'b0;
                drop   <= outstanding;
            end else begin
                if (consume)
                    vld_p1 <= 1'b0;
                if (drop && mem_valid_in)
                    drop <= 1'b0;
                case (state)
                    FETCH: begin
                        if (issue)
                            state <= WAIT_MEM;
                    end
                    WAIT_MEM: begin
                        if (mem_valid_in) begin
                            vld_p1 <= 1'b1;
                            if (dec_jal_p0) begin
                                pc    <= pc + imm_j;
                                state <= FETCH;
                            end else if (dec_jalr_p0) begin
                                pc      <= pc + 32'd4;
                                jalr_pc <= pc;
                                state   <= WAIT_JALR;
                            end else begin
                                pc    <= pc + 32'd4;
                                state <= FETCH;
                            end
                        end
                    end
                    WAIT_JALR: begin
                        if (jalr_done_in) begin
                            pc    <= jalr_target_in & ~32'h1;
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule
